load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory stage directly downstream of the ALU. Takes the ALU result as the effective address and rs2 as store data.
- Issues one data-memory request per memory instruction over a valid/ready request channel and waits for a valid-only response channel.
- Aligns and sign/zero-extends load data for writeback.
- Stalls the core through o_ex_ready while an access is in flight; one outstanding access at a time.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported; the lane and strobe logic is fixed to 4 bytes.

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  synchronous, active-high reset
- i_ex_valid  in  1  execute stage presents a memory instruction
- o_ex_ready  out  1  LSU can accept an instruction
- i_ex_load  in  1  1 = load, 0 = store
- i_ex_funct3  in  3  RV32I load/store funct3
- i_ex_addr  in  XLEN  effective address (ALU result)
- i_ex_wdata  in  XLEN  store data (rs2)
- o_dm_req_valid  out  1  memory request valid
- i_dm_req_ready  in  1  memory accepts request
- o_dm_req_we  out  1  1 = write
- o_dm_req_addr  out  XLEN  word-aligned address, bits [1:0] = 0
- o_dm_req_wdata  out  XLEN  lane-replicated store data
- o_dm_req_strb  out  XLEN/8  byte write strobes; 0 for reads
- i_dm_rsp_valid  in  1  read data valid
- i_dm_rsp_rdata  in  XLEN  read word
- o_done  out  1  one-cycle completion pulse (load, store or fault)
- o_wb_we  out  1  equals o_done AND load AND NOT fault
- o_wb_data  out  XLEN  extended load result, valid while o_wb_we
- o_fault  out  1  with o_done: illegal funct3 or misaligned access (misaligned only with the macro)

Behaviour:
- **Reset:** FSM returns to IDLE. All outputs reset to 0 except o_ex_ready = 1. All captured registers are cleared.
- **FSM states:** IDLE, REQ, RSP, DONE. State encoding is a local enum.
- **IDLE:**
  - o_ex_ready = 1.
  - On i_ex_valid, capture load, funct3, addr and wdata.
  - Illegal funct3 (loads 011/110/111, stores 011 and up) or a fault condition: go to DONE with fault set.
  - Otherwise go to REQ.
- **REQ:**
  - o_dm_req_valid = 1; all request fields come from registers and are held stable until i_dm_req_ready.
  - On the handshake: store goes to DONE, load goes to RSP.
- **RSP:**
  - Wait for i_dm_rsp_valid, then register the extended data and go to DONE.
  - A response arriving in the same cycle as the request handshake is illegal (the memory is at least 1 cycle).
- **DONE:** o_done = 1 for exactly one cycle, then go to IDLE.
- **Outside RSP:** i_dm_rsp_valid is ignored.
- **o_ex_ready:** 0 in every state except IDLE.
- **Latency with zero-wait memory:**
  - Accept at cycle 0, request handshake at cycle 1.
  - Store: o_done at cycle 2.
  - Load with response at cycle 2: o_done at cycle 3.
- **Store strobes:**
  - SB: 4'b0001 << addr[1:0]
  - SH: 4'b0011 << {addr[1],1'b0}
  - SW: 4'b1111
- **Store data:** SB replicates wdata[7:0] x4; SH replicates wdata[15:0] x2; SW passes wdata through unchanged.
- **Load extraction:**
  - Shift rdata right by 8*addr[1:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- **Reset mid-operation:** the in-flight access is abandoned and o_done is not pulsed. The integrator resets data memory in the same cycle, so no stale response is outstanding.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- **Defined:** a halfword access with addr[0] = 1, or a word access with addr[1:0] != 0, goes IDLE -> DONE with o_fault = 1. No memory request is issued and o_wb_we = 0.
- **Undefined:** the offending low address bits are forced to 0 (natural alignment) and the access proceeds normally. o_fault is then raised only for illegal funct3.

Decomposition:
- **Core package:** funct3 constants LsuB = 3'b000, LsuH = 3'b001, LsuW = 3'b010, LsuBu = 3'b100, LsuHu = 3'b101, and a strobe-width localparam.
- **Local to the module:** FSM enum.
- **Sub-module lsu_load_align:** combinational; inputs rdata, addr[1:0], funct3; output extended XLEN data. It is unit-testable on its own.

Test Plan:
- SB, addr 0x0000_1003, wdata 0x0000_00AB, ready high -> req addr 0x0000_1000, strb 4'b1000, wdata 0xABAB_ABAB, we = 1. o_done at cycle 2; o_wb_we = 0.
- LH, addr 0x0000_2002, rsp rdata 0x8001_1234 -> o_wb_data 0xFFFF_8001. Same access as LHU -> 0x0000_8001. LB at addr 0x2001 -> 0x0000_0012.
- LW with i_dm_req_ready held low 3 cycles -> request fields stable every cycle and o_ex_ready = 0 throughout. After ready and rsp 0xDEAD_BEEF: o_wb_data 0xDEAD_BEEF and a single o_done pulse.
- LW, addr 0x0000_3001:
  - With LSU_MISALIGN_TRAP_EN: o_fault = o_done = 1 at cycle 1, o_dm_req_valid never asserted.
  - Without it: req addr 0x0000_3000, normal completion.
- Load with funct3 = 3'b011 -> o_done and o_fault, no request, o_wb_we = 0.
- i_rst asserted while in RSP -> next cycle o_ex_ready = 1 and all other outputs 0. A response pulse injected afterwards produces no o_done.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: RV32I load/store funct3 codes,
// strobe width and the funct3 legality rule.
package load_store_unit_pkg;

    localparam int LsuStrbW = 4;

    localparam logic [2:0] LsuB  = 3'b000;
    localparam logic [2:0] LsuH  = 3'b001;
    localparam logic [2:0] LsuW  = 3'b010;
    localparam logic [2:0] LsuBu = 3'b100;
    localparam logic [2:0] LsuHu = 3'b101;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic lsu_funct3_legal(input logic is_load, input logic [2:0] funct3);
        if (is_load) begin
            return (funct3 == LsuB) || (funct3 == LsuH) || (funct3 == LsuW) ||
                   (funct3 == LsuBu) || (funct3 == LsuHu);
        end
        return (funct3 == LsuB) || (funct3 == LsuH) || (funct3 == LsuW);
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load-data aligner: selects the addressed byte/halfword/word
// from a read word and sign- or zero-extends it for writeback.
module lsu_load_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        data_o  = '0;
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        case (funct3_i)
            LsuB:    data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            LsuH:    data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            LsuBu:   data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            LsuHu:   data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one outstanding data-memory access, registered
// request and writeback outputs. Define LSU_MISALIGN_TRAP_EN to fault on misaligned accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_ex_valid,
    output logic                o_ex_ready,
    input  logic                i_ex_load,
    input  logic [2:0]          i_ex_funct3,
    input  logic [XLEN-1:0]     i_ex_addr,
    input  logic [XLEN-1:0]     i_ex_wdata,
    output logic                o_dm_req_valid,
    input  logic                i_dm_req_ready,
    output logic                o_dm_req_we,
    output logic [XLEN-1:0]     o_dm_req_addr,
    output logic [XLEN-1:0]     o_dm_req_wdata,
    output logic [LsuStrbW-1:0] o_dm_req_strb,
    input  logic                i_dm_rsp_valid,
    input  logic [XLEN-1:0]     i_dm_rsp_rdata,
    output logic                o_done,
    output logic                o_wb_we,
    output logic [XLEN-1:0]     o_wb_data,
    output logic                o_fault
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRsp,
        StDone
    } state_e;

    state_e                state_q;
    logic                  load_q;
    logic [2:0]            funct3_q;
    logic [1:0]            addr_lo_q;
    logic                  ex_ready_q;
    logic                  req_valid_q;
    logic                  req_we_q;
    logic [XLEN-1:0]       req_addr_q;
    logic [XLEN-1:0]       req_wdata_q;
    logic [LsuStrbW-1:0]   req_strb_q;
    logic                  done_q;
    logic                  wb_we_q;
    logic [XLEN-1:0]       wb_data_q;
    logic                  fault_q;

    logic [1:0]            addr_lo_d;
    logic                  fault_d;
    logic [LsuStrbW-1:0]   req_strb_d;
    logic [XLEN-1:0]       req_wdata_d;
    logic [XLEN-1:0]       align_data;

    // Accept-time decode of the incoming instruction; only used in StIdle.
    always_comb begin
        addr_lo_d   = i_ex_addr[1:0];
        fault_d     = !lsu_funct3_legal(i_ex_load, i_ex_funct3);
        req_strb_d  = '0;
        req_wdata_d = i_ex_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((i_ex_funct3[1:0] == 2'b01 && i_ex_addr[0]) ||
            (i_ex_funct3[1:0] == 2'b10 && i_ex_addr[1:0] != 2'b00)) begin
            fault_d = 1'b1;
        end
`else
        if (i_ex_funct3[1:0] == 2'b01) begin
            addr_lo_d[0] = 1'b0;
        end else if (i_ex_funct3[1:0] == 2'b10) begin
            addr_lo_d = 2'b00;
        end
`endif
        case (i_ex_funct3[1:0])
            2'b00: begin
                req_strb_d  = 4'b0001 << addr_lo_d;
                req_wdata_d = {4{i_ex_wdata[7:0]}};
            end
            2'b01: begin
                req_strb_d  = 4'b0011 << {addr_lo_d[1], 1'b0};
                req_wdata_d = {2{i_ex_wdata[15:0]}};
            end
            default: begin
                req_strb_d  = 4'b1111;
                req_wdata_d = i_ex_wdata;
            end
        endcase
        if (i_ex_load) begin
            req_strb_d = '0;
        end
    end

    lsu_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .rdata_i   (i_dm_rsp_rdata),
        .addr_lo_i (addr_lo_q),
        .funct3_i  (funct3_q),
        .data_o    (align_data)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: data registers are reset too, so all outputs read a defined 0 after reset.
            state_q     <= StIdle;
            load_q      <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            ex_ready_q  <= 1'b1;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_strb_q  <= '0;
            done_q      <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_data_q   <= '0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_ex_valid) begin
                        load_q      <= i_ex_load;
                        funct3_q    <= i_ex_funct3;
                        addr_lo_q   <= addr_lo_d;
                        req_we_q    <= !i_ex_load;
                        req_addr_q  <= {i_ex_addr[XLEN-1:2], 2'b00};
                        req_wdata_q <= req_wdata_d;
                        req_strb_q  <= req_strb_d;
                        ex_ready_q  <= 1'b0;
                        if (fault_d) begin
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            req_valid_q <= 1'b1;
                            state_q     <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (i_dm_req_ready) begin
                        req_valid_q <= 1'b0;
                        if (load_q) begin
                            state_q <= StRsp;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StRsp: begin
                    if (i_dm_rsp_valid) begin
                        wb_data_q <= align_data;
                        wb_we_q   <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    done_q     <= 1'b0;
                    wb_we_q    <= 1'b0;
                    fault_q    <= 1'b0;
                    ex_ready_q <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_ex_ready     = ex_ready_q;
    assign o_dm_req_valid = req_valid_q;
    assign o_dm_req_we    = req_we_q;
    assign o_dm_req_addr  = req_addr_q;
    assign o_dm_req_wdata = req_wdata_q;
    assign o_dm_req_strb  = req_strb_q;
    assign o_done         = done_q;
    assign o_wb_we        = wb_we_q;
    assign o_wb_data      = wb_data_q;
    assign o_fault        = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random accesses
// checked against a byte-level reference model.
module tb_load_store_unit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ex_valid = 1'b0;
    logic        o_ex_ready;
    logic        i_ex_load = 1'b0;
    logic [2:0]  i_ex_funct3 = 3'b000;
    logic [31:0] i_ex_addr = '0;
    logic [31:0] i_ex_wdata = '0;
    logic        o_dm_req_valid;
    logic        i_dm_req_ready = 1'b0;
    logic        o_dm_req_we;
    logic [31:0] o_dm_req_addr;
    logic [31:0] o_dm_req_wdata;
    logic [3:0]  o_dm_req_strb;
    logic        i_dm_rsp_valid = 1'b0;
    logic [31:0] i_dm_rsp_rdata = '0;
    logic        o_done;
    logic        o_wb_we;
    logic [31:0] o_wb_data;
    logic        o_fault;

    int checks = 0;
    int failures = 0;

    load_store_unit #(.XLEN(32)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_ex_valid     (i_ex_valid),
        .o_ex_ready     (o_ex_ready),
        .i_ex_load      (i_ex_load),
        .i_ex_funct3    (i_ex_funct3),
        .i_ex_addr      (i_ex_addr),
        .i_ex_wdata     (i_ex_wdata),
        .o_dm_req_valid (o_dm_req_valid),
        .i_dm_req_ready (i_dm_req_ready),
        .o_dm_req_we    (o_dm_req_we),
        .o_dm_req_addr  (o_dm_req_addr),
        .o_dm_req_wdata (o_dm_req_wdata),
        .o_dm_req_strb  (o_dm_req_strb),
        .i_dm_rsp_valid (i_dm_rsp_valid),
        .i_dm_rsp_rdata (i_dm_rsp_rdata),
        .o_done         (o_done),
        .o_wb_we        (o_wb_we),
        .o_wb_data      (o_wb_data),
        .o_fault        (o_fault)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Reference model: access size in bytes, alignment and extension from funct3 rules.
    function automatic bit model_illegal(input bit ld, input logic [2:0] f3);
        if (ld) return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        return f3 >= 3'd3;
    endfunction

    function automatic int model_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr[1:0]) % model_size(f3)) != 0;
    endfunction

    function automatic int model_offset(input logic [2:0] f3, input logic [31:0] addr);
        int sz = model_size(f3);
        int a = int'(addr[1:0]);
        return a - (a % sz);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] r = '0;
        int sz = model_size(f3);
        for (int i = 0; i < 4; i++) begin
            r = r | (((wdata >> (8 * (i % sz))) & 32'hFF) << (8 * i));
        end
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int sz = model_size(f3);
        logic [31:0] v = rdata >> (8 * model_offset(f3, addr));
        logic [31:0] mask;
        if (sz < 4) begin
            mask = (32'd1 << (8 * sz)) - 32'd1;
            v = v & mask;
            if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    // One complete access: drive, then check every cycle until back in idle.
    task automatic do_access(input string name, input bit ld, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int rdy_dly, input int rsp_dly);
        bit fault;
        logic [31:0] exp_strb;
        fault = model_illegal(ld, f3);
`ifdef LSU_MISALIGN_TRAP_EN
        if (!fault && model_misaligned(f3, addr)) fault = 1'b1;
`endif
        exp_strb = ld ? 32'd0 : ((32'd1 << model_size(f3)) - 32'd1) << model_offset(f3, addr);

        check({name, ":idle_ready"}, 32'(o_ex_ready), 32'd1);
        i_ex_valid  = 1'b1;
        i_ex_load   = ld;
        i_ex_funct3 = f3;
        i_ex_addr   = addr;
        i_ex_wdata  = wdata;
        tick();
        i_ex_valid = 1'b0;
        i_ex_addr  = $urandom;
        i_ex_wdata = $urandom;

        if (fault) begin
            check({name, ":fault_done"}, 32'(o_done), 32'd1);
            check({name, ":fault"}, 32'(o_fault), 32'd1);
            check({name, ":fault_no_req"}, 32'(o_dm_req_valid), 32'd0);
            check({name, ":fault_wb_we"}, 32'(o_wb_we), 32'd0);
            tick();
            check({name, ":fault_done_clr"}, 32'(o_done), 32'd0);
            check({name, ":fault_ready"}, 32'(o_ex_ready), 32'd1);
            return;
        end

        for (int k = 0; k <= rdy_dly; k++) begin
            i_dm_req_ready = (k == rdy_dly);
            i_dm_rsp_valid = (k != rdy_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_dm_rsp_rdata = $urandom;
            check({name, ":req_valid"}, 32'(o_dm_req_valid), 32'd1);
            check({name, ":req_we"}, 32'(o_dm_req_we), 32'(!ld));
            check({name, ":req_addr"}, o_dm_req_addr, {addr[31:2], 2'b00});
            check({name, ":req_strb"}, 32'(o_dm_req_strb), exp_strb);
            if (!ld) check({name, ":req_wdata"}, o_dm_req_wdata, model_wdata(f3, wdata));
            check({name, ":req_ex_ready"}, 32'(o_ex_ready), 32'd0);
            check({name, ":req_no_done"}, 32'(o_done), 32'd0);
            tick();
        end
        i_dm_req_ready = 1'b0;
        i_dm_rsp_valid = 1'b0;
        check({name, ":req_dropped"}, 32'(o_dm_req_valid), 32'd0);

        if (ld) begin
            for (int k = 0; k <= rsp_dly; k++) begin
                i_dm_rsp_valid = (k == rsp_dly);
                i_dm_rsp_rdata = (k == rsp_dly) ? rdata : $urandom;
                check({name, ":rsp_wait"}, 32'(o_done), 32'd0);
                tick();
            end
            i_dm_rsp_valid = 1'b0;
            check({name, ":ld_wb_data"}, o_wb_data, model_load(f3, addr, rdata));
            check({name, ":ld_wb_we"}, 32'(o_wb_we), 32'd1);
        end else begin
            check({name, ":st_wb_we"}, 32'(o_wb_we), 32'd0);
        end
        check({name, ":done"}, 32'(o_done), 32'd1);
        check({name, ":no_fault"}, 32'(o_fault), 32'd0);
        check({name, ":done_ex_ready"}, 32'(o_ex_ready), 32'd0);
        tick();
        check({name, ":done_pulse"}, 32'(o_done), 32'd0);
        check({name, ":wb_we_clr"}, 32'(o_wb_we), 32'd0);
        check({name, ":back_ready"}, 32'(o_ex_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ":ex_ready"}, 32'(o_ex_ready), 32'd1);
        check({name, ":req_valid"}, 32'(o_dm_req_valid), 32'd0);
        check({name, ":req_we"}, 32'(o_dm_req_we), 32'd0);
        check({name, ":req_addr"}, o_dm_req_addr, 32'd0);
        check({name, ":req_wdata"}, o_dm_req_wdata, 32'd0);
        check({name, ":req_strb"}, 32'(o_dm_req_strb), 32'd0);
        check({name, ":done"}, 32'(o_done), 32'd0);
        check({name, ":wb_we"}, 32'(o_wb_we), 32'd0);
        check({name, ":wb_data"}, o_wb_data, 32'd0);
        check({name, ":fault"}, 32'(o_fault), 32'd0);
    endtask

    initial begin
        i_rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        i_rst = 1'b0;
        tick();

        do_access("sb_1003", 1'b0, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 0);
        do_access("lh_2002", 1'b1, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0);
        do_access("lhu_2002", 1'b1, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0);
        do_access("lb_2001", 1'b1, 3'b000, 32'h0000_2001, 32'h0, 32'h8001_1234, 0, 0);
        do_access("lw_stall", 1'b1, 3'b010, 32'h0000_2000, 32'h0, 32'hDEAD_BEEF, 3, 2);
        do_access("lw_3001", 1'b1, 3'b010, 32'h0000_3001, 32'h0, 32'h1234_5678, 0, 0);
        do_access("ld_f3_011", 1'b1, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 0, 0);
        do_access("sh_0003", 1'b0, 3'b001, 32'h0000_0003, 32'hCAFE_5A5A, 32'h0, 1, 0);
        do_access("sw_0008", 1'b0, 3'b010, 32'h0000_0008, 32'h0123_4567, 32'h0, 0, 0);
        do_access("st_f3_100", 1'b0, 3'b100, 32'h0000_0010, 32'h1, 32'h0, 0, 0);

        // Reset while waiting for a load response abandons the access.
        i_ex_valid  = 1'b1;
        i_ex_load   = 1'b1;
        i_ex_funct3 = 3'b010;
        i_ex_addr   = 32'h0000_4000;
        tick();
        i_ex_valid     = 1'b0;
        i_dm_req_ready = 1'b1;
        tick();
        i_dm_req_ready = 1'b0;
        check("rsp_state:ex_ready", 32'(o_ex_ready), 32'd0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check_reset_outputs("mid_reset");
        i_dm_rsp_valid = 1'b1;
        i_dm_rsp_rdata = 32'h5555_AAAA;
        tick();
        i_dm_rsp_valid = 1'b0;
        check("stale_rsp:done", 32'(o_done), 32'd0);
        check("stale_rsp:wb_we", 32'(o_wb_we), 32'd0);
        tick();
        check("stale_rsp:done2", 32'(o_done), 32'd0);
        check("stale_rsp:ready", 32'(o_ex_ready), 32'd1);

        for (int n = 0; n < 60; n++) begin
            do_access("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                      $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
